// File: rtl/serial_const_divider_if.sv
// Handshake bundle for serial_const_divider: start/operands in, status and result out.
// The divider sits on the slave modport and the requester on the master modport.
interface serial_const_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [3:0]       rin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [3:0]       r;
    logic             err;

    modport master (
        output start, x, rin,
        input  busy, done, q, r, err
    );

    modport slave (
        input  start, x, rin,
        output busy, done, q, r, err
    );
endinterface

// File: rtl/serial_const_divider.sv
// Bit-serial restoring divider by a small constant: one dividend bit per clock, MSB first,
// with a carry-in remainder so long dividends can be processed in WIDTH-bit chunks.
module serial_const_divider #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_const_divider_if.slave bus
);
    generate
        if (DIVISOR < 2 || DIVISOR > 15) begin : g_bad_divisor
            $error("serial_const_divider: DIVISOR must be in 2..15");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_const_divider: WIDTH must be in 2..32");
        end
    endgenerate

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [3:0]     DIV4 = 4'(DIVISOR);
    localparam logic [4:0]     DIV5 = 5'(DIVISOR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] q_reg;
    logic [3:0]       rem_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic [4:0] step_t;
    logic [4:0] step_diff;
    logic       step_qbit;
    logic [3:0] step_rem;

    // One restoring step: t = 2*rem + next dividend bit; rem < DIVISOR keeps t within 5 bits.
    always_comb begin
        step_t    = {rem_reg, sh_reg[WIDTH-1]};
        step_diff = step_t - DIV5;
        step_qbit = (step_t >= DIV5);
        step_rem  = step_qbit ? step_diff[3:0] : step_t[3:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sh_reg    <= '0;
            q_reg     <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        q_reg   <= '0;
                        rem_reg <= bus.rin;
                        if (bus.rin >= DIV4) begin
                            // Carry-in already too large: report it without running.
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            sh_reg    <= bus.x;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    sh_reg  <= {sh_reg[WIDTH-2:0], 1'b0};
                    q_reg   <= {q_reg[WIDTH-2:0], step_qbit};
                    rem_reg <= step_rem;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.err  = err_reg;
    assign bus.q    = q_reg;
    assign bus.r    = rem_reg;
endmodule

// File: tb/tb_serial_const_divider.sv
// Drives two dividers (DIVISOR 3 and 7, WIDTH 8) with identical stimulus and checks both
// against plain integer division of rin*2^8 + x, including timing, err and hold behaviour.
module tb_serial_const_divider;
    localparam int W = 8;

    int divs[2] = '{3, 7};

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x     = '0;
    logic [3:0] rin   = '0;

    int checks = 0;
    int errors = 0;

    serial_const_divider_if #(.WIDTH(W)) if3 ();
    serial_const_divider_if #(.WIDTH(W)) if7 ();

    assign if3.start = start;
    assign if3.x     = x;
    assign if3.rin   = rin;
    assign if7.start = start;
    assign if7.x     = x;
    assign if7.rin   = rin;

    serial_const_divider #(.WIDTH(W), .DIVISOR(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    serial_const_divider #(.WIDTH(W), .DIVISOR(7)) dut7 (.clk(clk), .reset(reset), .bus(if7));

    always #5 clk = ~clk;

    logic       busy_o[2];
    logic       done_o[2];
    logic       err_o[2];
    logic [7:0] q_o[2];
    logic [3:0] r_o[2];

    assign busy_o[0] = if3.busy;
    assign done_o[0] = if3.done;
    assign err_o[0]  = if3.err;
    assign q_o[0]    = if3.q;
    assign r_o[0]    = if3.r;
    assign busy_o[1] = if7.busy;
    assign done_o[1] = if7.done;
    assign err_o[1]  = if7.err;
    assign q_o[1]    = if7.q;
    assign r_o[1]    = if7.r;

    task automatic accept_edge();
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 8'($urandom);
        rin   = 4'($urandom);
    endtask

    task automatic launch(input logic [7:0] xv, input logic [3:0] rv);
        start = 1'b1;
        x     = xv;
        rin   = rv;
        accept_edge();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after the start-accepting edge; n counts edges since then.
    task automatic check_op(input logic [7:0] xv, input logic [3:0] rv,
                            input bit repulse, input bit chain, input string tag);
        int  lat[2];
        int  eq[2];
        int  er[2];
        bit  ee[2];
        int  num;
        int  last;
        num = int'(rv) * 256 + int'(xv);
        for (int d = 0; d < 2; d++) begin
            if (int'(rv) >= divs[d]) begin
                lat[d] = 0; eq[d] = 0; er[d] = int'(rv); ee[d] = 1'b1;
            end else begin
                lat[d] = W; eq[d] = num / divs[d]; er[d] = num % divs[d]; ee[d] = 1'b0;
            end
        end
        $display("op %s div3/div7 x=%0d rin=%0d exp q=%0d/%0d r=%0d/%0d err=%0b/%0b",
                 tag, xv, rv, eq[0], eq[1], er[0], er[1], ee[0], ee[1]);
        last = chain ? W : W + 2;
        for (int n = 0; n <= last; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (done_o[d] !== (n == lat[d])) begin
                    errors++;
                    $display("FAIL %s div%0d n=%0d done got %b want %b", tag, divs[d], n, done_o[d], (n == lat[d]));
                end
                checks++;
                if (busy_o[d] !== (!ee[d] && n < W)) begin
                    errors++;
                    $display("FAIL %s div%0d n=%0d busy got %b want %b", tag, divs[d], n, busy_o[d], (!ee[d] && n < W));
                end
                if (n >= lat[d]) begin
                    checks++;
                    if (q_o[d] !== 8'(eq[d])) begin
                        errors++;
                        $display("FAIL %s div%0d n=%0d q got %0d want %0d", tag, divs[d], n, q_o[d], eq[d]);
                    end
                    checks++;
                    if (r_o[d] !== 4'(er[d])) begin
                        errors++;
                        $display("FAIL %s div%0d n=%0d r got %0d want %0d", tag, divs[d], n, r_o[d], er[d]);
                    end
                end
                checks++;
                if (err_o[d] !== (ee[d] && n == lat[d])) begin
                    errors++;
                    $display("FAIL %s div%0d n=%0d err got %b want %b", tag, divs[d], n, err_o[d], (ee[d] && n == lat[d]));
                end
            end
            if (repulse) begin
                if (n == 2) begin
                    start = 1'b1;
                    x     = 8'($urandom);
                    rin   = 4'($urandom);
                end else if (n == 3) begin
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_o[d], done_o[d], err_o[d], q_o[d], r_o[d]} !== 15'd0) begin
                errors++;
                $display("FAIL %s div%0d outputs got busy=%b done=%b err=%b q=%0d r=%0d want all 0",
                         tag, divs[d], busy_o[d], done_o[d], err_o[d], q_o[d], r_o[d]);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset = 1'b0;
        launch(8'd200, 4'd0);
        check_op(8'd200, 4'd0, 1'b0, 1'b0, "first_after_reset");
    endtask

    task automatic test_directed();
        launch(8'd0, 4'd2);
        check_op(8'd0, 4'd2, 1'b0, 1'b0, "x0_rin2");
        launch(8'd255, 4'd0);
        check_op(8'd255, 4'd0, 1'b0, 1'b0, "x255_rin0");
        launch(8'd37, 4'd3);
        check_op(8'd37, 4'd3, 1'b0, 1'b0, "rin3_err3");
        launch(8'd255, 4'd6);
        check_op(8'd255, 4'd6, 1'b0, 1'b0, "rin6_max7");
        launch(8'd1, 4'd15);
        check_op(8'd1, 4'd15, 1'b0, 1'b0, "rin15_err");
    endtask

    task automatic test_ignored_start();
        launch(8'd100, 4'd0);
        check_op(8'd100, 4'd0, 1'b1, 1'b0, "repulse_x100");
    endtask

    task automatic test_back_to_back();
        launch(8'd77, 4'd1);
        check_op(8'd77, 4'd1, 1'b0, 1'b1, "b2b_first");
        start = 1'b1;
        x     = 8'd9;
        rin   = 4'd0;
        accept_edge();
        check_op(8'd9, 4'd0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid_run();
        launch(8'd200, 4'd1);
        idle_cycles(4);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_run");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < W + 4; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (done_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL after_abort div%0d n=%0d done/busy got %b%b want 00",
                             divs[d], n, done_o[d], busy_o[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] xv;
        logic [3:0] rv;
        bit         rep;
        for (int i = 0; i < 30; i++) begin
            xv  = 8'($urandom);
            rv  = 4'($urandom_range(0, 15));
            rep = (rv < 4'd3) && ($urandom_range(0, 1) == 1);
            launch(xv, rv);
            check_op(xv, rv, rep, 1'b0, "random");
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_const_divider.md
SERIAL_CONST_DIVIDER -- requirements
Module: serial_const_divider

Interface
REQ-001 Parameter WIDTH, default 8, dividend and quotient width in bits; legal range 2..32.
REQ-002 Parameter DIVISOR, default 3, constant divisor; legal range 2..15; out-of-range values SHALL fail elaboration.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled on rising clk edge.
REQ-006 x  input  WIDTH  unsigned dividend; sampled with an accepted start.
REQ-007 rin  input  4  initial (carry-in) remainder; sampled with an accepted start.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  single-cycle pulse; q, r, err valid.
REQ-010 q  output  WIDTH  quotient of (rin*2^WIDTH + x) / DIVISOR.
REQ-011 r  output  4  remainder of (rin*2^WIDTH + x) mod DIVISOR.
REQ-012 err  output  1  high with done when rin >= DIVISOR.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, no effect on q, r or the count.
REQ-015 On accepted start with rin < DIVISOR: load x into shift register, rin into remainder register, zero bit counter, go to RUN.
REQ-016 In RUN, one dividend bit per cycle, MSB first: t = 2*rem + bit (5-bit intermediate); if t >= DIVISOR, quotient bit 1 and rem = t - DIVISOR, else quotient bit 0 and rem = t.
REQ-017 Quotient bits SHALL shift into q from the LSB; q SHALL hold the partial quotient during RUN.
REQ-018 RUN SHALL last exactly WIDTH cycles; then DONE for exactly one cycle, returning to IDLE unless a new start is accepted.
REQ-019 done SHALL rise WIDTH cycles after the start-accepting edge; busy high for exactly those WIDTH cycles.
REQ-020 busy SHALL be high in RUN only; done high in DONE only; never both.
REQ-021 On accepted start with rin >= DIVISOR: skip RUN, enter DONE next cycle with err=1, q=0, r=rin.
REQ-022 err SHALL be 0 on every done not caused by REQ-021, and 0 outside DONE.
REQ-023 q and r SHALL hold their final values from DONE until the next accepted start.
REQ-024 Start accepted in DONE SHALL begin a new operation on that edge (back-to-back, no idle gap); done still pulses for the completing result.
REQ-025 r SHALL always be < DIVISOR after a non-error completion; q SHALL not overflow since rin < DIVISOR.
REQ-026 Changes on x or rin outside an accepted start SHALL not affect an operation in progress.

Reset
REQ-027 reset high SHALL immediately force IDLE, busy=0, done=0, err=0, q=0, r=0, counter=0, independent of clk.
REQ-028 Reset asserted during RUN SHALL abort the operation; no done pulse for it after release.
REQ-029 First start after reset release SHALL be accepted on the first rising edge where reset is low.

Verification
REQ-030 WIDTH=8, DIVISOR=3, x=200, rin=0 -> done 8 cycles after start, q=66, r=2, err=0.
REQ-031 WIDTH=8, DIVISOR=3, x=0x00, rin=2 -> q=170, r=2; x=255, rin=0 -> q=85, r=0.
REQ-032 WIDTH=8, DIVISOR=3, rin=3 -> done one cycle after start, err=1, q=0, r=3, busy never high.
REQ-033 WIDTH=8, DIVISOR=7, x=100, rin=0 -> q=14, r=2; start re-pulsed in cycle 3 of RUN -> ignored, same result and timing.
REQ-034 Start asserted in DONE cycle with x=9 -> first result still pulses done; second done 8 cycles later, q=3, r=0 (DIVISOR=3).
REQ-035 reset asserted mid-RUN (cycle 4) -> busy, done, q, r drop to 0 before next clk edge; no done after release.
